// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer for a 4-bit universal shift register.
// One command per handshake: it drives S/D/SDL/SDR for exactly the number
// of clock edges the command needs, then pulses DONE for one cycle.
//
// Handshake: a command transfers on a rising CLK edge where CMD_VALID and
// CMD_READY are both high. CMD_READY is high only in IDLE. CMD_VALID in any
// other state is ignored and never queued. The producer may hold CMD_VALID
// and its payload until it sees the transfer.
module shift_seq_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             CLRb,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic [3:0]       CMD_D,
  input  logic             SIN,
  input  logic             ABORT,
  input  logic [3:0]       Q_FB,
  output logic [1:0]       S,
  output logic [3:0]       D,
  output logic             SDL,
  output logic             SDR,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  state_t           state_q, state_n;
  logic [1:0]       op_q, op_n;
  logic [3:0]       d_q, d_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic [1:0]       s_q, s_n;
  logic             aborted_q, aborted_n;

  // State and registered outputs; reset forces hold mode so a killed
  // command issues no further steps.
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      d_q       <= 4'b0000;
      rem_q     <= '0;
      s_q       <= S_HOLD;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      op_q      <= op_n;
      d_q       <= d_n;
      rem_q     <= rem_n;
      s_q       <= s_n;
      aborted_q <= aborted_n;
    end
  end

  // Next-state logic: S is computed one edge ahead so the register sees the
  // mode during exactly the edges that perform steps.
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    d_n       = d_q;
    rem_n     = rem_q;
    s_n       = s_q;
    aborted_n = aborted_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          op_n  = CMD_OP;
          rem_n = (CMD_OP == OP_LOAD) ? CNT_W'(1) : CMD_CNT;
          if (CMD_OP == OP_LOAD) d_n = CMD_D;
          if (rem_n != '0) begin
            state_n = ST_RUN;
            unique case (CMD_OP)
              OP_LOAD: s_n = S_LOAD;
              OP_SHR:  s_n = S_SHR;
              OP_SHL:  s_n = S_SHL;
              OP_ROL:  s_n = S_SHL;
              default: s_n = S_HOLD;
            endcase
          end else begin
            state_n = ST_DONE;
            s_n     = S_HOLD;
          end
        end
      end
      ST_RUN: begin
        // This edge is a step whether or not ABORT is high.
        rem_n = rem_q - CNT_W'(1);
        if (ABORT || rem_q == CNT_W'(1)) begin
          state_n   = ST_DONE;
          s_n       = S_HOLD;
          aborted_n = ABORT;
        end
      end
      ST_DONE: begin
        state_n   = ST_IDLE;
        aborted_n = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        s_n     = S_HOLD;
      end
    endcase
  end

  // Serial feed: passed straight through so the register samples SIN and
  // the pre-edge Q at the very edge that shifts.
  always_comb begin
    SDL = 1'b0;
    SDR = 1'b0;
    if (state_q == ST_RUN) begin
      unique case (op_q)
        OP_SHL:  SDL = SIN;
        OP_ROL:  SDL = Q_FB[3];
        OP_SHR:  SDR = SIN;
        default: begin
          SDL = 1'b0;
          SDR = 1'b0;
        end
      endcase
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign BUSY      = !CMD_READY;
  assign DONE      = (state_q == ST_DONE);
  assign ABORTED   = aborted_q;
  assign S         = s_q;
  assign D         = d_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl, with a behavioural 4-bit universal
// shift register closing the Q_FB loop.
module tb_shift_seq_ctrl;

  logic       CLK = 1'b0;
  logic       CLRb = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [2:0] CMD_CNT = 3'd0;
  logic [3:0] CMD_D = 4'b0000;
  logic       SIN = 1'b0;
  logic       ABORT = 1'b0;
  logic [3:0] Q_FB;
  logic [1:0] S;
  logic [3:0] D;
  logic       SDL, SDR, BUSY, DONE, ABORTED;
  logic [1:0] dbg_state;

  logic [3:0] q = 4'b0000;
  int total = 0;
  int bad = 0;

  shift_seq_ctrl #(.CNT_W(3)) dut (
    .CLK(CLK), .CLRb(CLRb), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_CNT(CMD_CNT), .CMD_D(CMD_D), .SIN(SIN),
    .ABORT(ABORT), .Q_FB(Q_FB), .S(S), .D(D), .SDL(SDL), .SDR(SDR),
    .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED), .dbg_state(dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Downstream universal shift register (not reset by CLRb)
  always @(posedge CLK) begin
    case (S)
      2'b11: q <= D;
      2'b10: q <= {q[2:0], SDL};
      2'b01: q <= {SDR, q[3:1]};
      default: q <= q;
    endcase
  end
  assign Q_FB = q;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a command in IDLE; it transfers at the next edge
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] d);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_CNT   = cnt;
    CMD_D     = d;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic load(input logic [3:0] d);
    issue(2'b00, 3'd0, d);
    tick();
    tick();
  endtask

  initial begin
    // Reset
    #2;
    chk("rst_s", 8'(S), 8'h0);
    chk("rst_d", 8'(D), 8'h0);
    chk("rst_sdl_sdr", 8'({SDL, SDR}), 8'h0);
    chk("rst_done_ab", 8'({DONE, ABORTED}), 8'h0);
    chk("rst_busy", 8'(BUSY), 8'h0);
    chk("rst_ready", 8'(CMD_READY), 8'h1);
    #1 CLRb = 1'b1;
    tick();

    // Load 1010
    issue(2'b00, 3'd5, 4'b1010);
    chk("ld_s", 8'(S), 8'h3);
    chk("ld_d", 8'(D), 8'ha);
    chk("ld_busy_ready", 8'({BUSY, CMD_READY}), 8'h2);
    tick();
    chk("ld_done", 8'({DONE, ABORTED}), 8'h2);
    chk("ld_s_hold", 8'(S), 8'h0);
    chk("ld_q", 8'(q), 8'ha);
    tick();
    chk("ld_idle", 8'({DONE, CMD_READY}), 8'h1);
    chk("ld_q_held", 8'(q), 8'ha);

    // Shift left 3 from 0001, SIN = 1,0,1
    load(4'b0001);
    chk("shl_pre_q", 8'(q), 8'h1);
    SIN = 1'b1;
    issue(2'b10, 3'd3, 4'b0000);
    #1;
    chk("shl_s", 8'(S), 8'h2);
    chk("shl_sdl_sdr", 8'({SDL, SDR}), 8'h2);
    tick();
    SIN = 1'b0;
    #1;
    chk("shl_sdl0", 8'(SDL), 8'h0);
    chk("shl_q1", 8'(q), 8'h3);
    tick();
    SIN = 1'b1;
    chk("shl_run2", 8'({S, DONE}), 8'h4);
    tick();
    SIN = 1'b0;
    chk("shl_done", 8'(DONE), 8'h1);
    chk("shl_q", 8'(q), 8'hd);
    chk("shl_s_hold", 8'(S), 8'h0);
    chk("shl_d_kept", 8'(D), 8'h1);
    tick();
    chk("shl_ready", 8'(CMD_READY), 8'h1);

    // Rotate left 5 from 1001
    load(4'b1001);
    issue(2'b11, 3'd5, 4'b0000);
    chk("rol_sdl_fb", 8'({SDL, SDR}), 8'h2);
    for (int i = 0; i < 4; i++) tick();
    chk("rol_busy_4", 8'({BUSY, DONE}), 8'h2);
    tick();
    chk("rol_done", 8'(DONE), 8'h1);
    chk("rol_q", 8'(q), 8'h3);
    tick();

    // Shift right 2 with SIN = 0
    issue(2'b01, 3'd2, 4'b0000);
    chk("shr_s", 8'(S), 8'h1);
    SIN = 1'b1;
    #1;
    chk("shr_sdr_pass", 8'({SDL, SDR}), 8'h1);
    SIN = 1'b0;
    tick();
    chk("shr_q1", 8'(q), 8'h1);
    tick();
    chk("shr_done", 8'(DONE), 8'h1);
    chk("shr_q", 8'(q), 8'h0);
    tick();

    // Abort at 2nd RUN edge of shift left 7 from 1111
    load(4'b1111);
    issue(2'b10, 3'd7, 4'b0000);
    tick();
    chk("ab_q1", 8'(q), 8'he);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("ab_done_ab", 8'({DONE, ABORTED}), 8'h3);
    chk("ab_q", 8'(q), 8'hc);
    chk("ab_s", 8'(S), 8'h0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("ab_clear", 8'({DONE, ABORTED, CMD_READY}), 8'h1);
    chk("ab_q_held", 8'(q), 8'hc);

    // CNT = 0 goes straight to DONE
    issue(2'b10, 3'd0, 4'b0000);
    chk("c0_done", 8'({DONE, S}), 8'h4);
    tick();
    chk("c0_q", 8'(q), 8'hc);
    chk("c0_ready", 8'(CMD_READY), 8'h1);

    // Second command held during RUN is taken once, after READY
    issue(2'b10, 3'd2, 4'b0000);
    CMD_VALID = 1'b1;
    CMD_OP    = 2'b00;
    CMD_D     = 4'b0110;
    tick();
    chk("st_s_run", 8'(S), 8'h2);
    chk("st_q1", 8'(q), 8'h8);
    tick();
    chk("st_done", 8'({DONE, S}), 8'h4);
    chk("st_q2", 8'(q), 8'h0);
    tick();
    chk("st_ready", 8'(CMD_READY), 8'h1);
    tick();
    CMD_VALID = 1'b0;
    chk("st_accept", 8'({S, BUSY}), 8'h7);
    tick();
    chk("st_q_ld", 8'(q), 8'h6);
    tick();
    tick();
    chk("st_once", 8'({BUSY, S}), 8'h0);
    chk("st_q_final", 8'(q), 8'h6);

    // Asynchronous reset mid-shift
    SIN = 1'b1;
    issue(2'b10, 3'd5, 4'b0000);
    tick();
    chk("ar_q1", 8'(q), 8'hd);
    #2 CLRb = 1'b0;
    #1;
    chk("ar_s", 8'(S), 8'h0);
    chk("ar_busy", 8'({BUSY, CMD_READY, DONE}), 8'h2);
    chk("ar_d", 8'(D), 8'h0);
    #2 CLRb = 1'b1;
    tick();
    chk("ar_no_done1", 8'({DONE, S}), 8'h0);
    tick();
    chk("ar_no_done2", 8'({DONE, BUSY}), 8'h0);
    chk("ar_q_held", 8'(q), 8'hd);
    SIN = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Command sequencer that sits directly upstream of the 4-bit universal shift register. It accepts one command per valid/ready handshake: parallel load, N-step shift left, N-step shift right, or N-step rotate left. It then drives the register's S, D, SDL and SDR inputs for exactly the required number of clock edges. Serial data is fed from SIN. Rotate feedback comes from the register's Q output.

## Interface
- CNT_W, default 3: width of the shift-count field; maximum count 2^CNT_W-1.
- CLK  in  1  rising-edge clock, shared with the shift register.
- CLRb  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  2  operation code:
  - 00: load CMD_D.
  - 01: shift right.
  - 10: shift left.
  - 11: rotate left.
- CMD_CNT  in  CNT_W  number of shift/rotate steps; ignored for load.
- CMD_D  in  4  parallel load data.
- SIN  in  1  serial input bit, passed through on every shift step.
- ABORT  in  1  terminate the running command.
- Q_FB  in  4  current Q of the shift register.
- S  out  2  mode select to the shift register:
  - 11: load.
  - 10: shift left.
  - 01: shift right.
  - 00: hold.
- D  out  4  parallel data to the shift register.
- SDL  out  1  serial-in for left shift (enters bit 0).
- SDR  out  1  serial-in for right shift (enters bit 3).
- BUSY  out  1  command in progress (RUN or DONE state).
- DONE  out  1  one-cycle completion pulse.
- ABORTED  out  1  qualifies DONE: the command was cut short by ABORT.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free; state is held in registers.
- CMD_READY = (state == IDLE). BUSY = !CMD_READY.
- IDLE:
  - On CMD_VALID, latch op, D and remaining = (op == 00) ? 1 : CMD_CNT.
  - If remaining ≠ 0, go to RUN with S = mapped mode (00→11, 01→01, 10→10, 11→10).
  - If remaining = 0 (shift or rotate with CNT = 0), go directly to DONE with S = 00.
- RUN:
  - Each edge decrements remaining.
  - When remaining == 1 at an edge, go to DONE and set S = 00.
  - ABORT = 1 at an edge: go to DONE, set S = 00 and ABORTED = 1. That edge still counts as a shift step, because the register samples the same edge.
- DONE: DONE = 1 for exactly one cycle; the next edge returns to IDLE and clears ABORTED.
- S, D and ABORTED are registered.
- SDL and SDR are combinational from state, latched op, SIN and Q_FB:
  - Shift left: SDL = SIN, SDR = 0.
  - Rotate left: SDL = Q_FB[3], SDR = 0.
  - Shift right: SDR = SIN, SDL = 0.
  - Any other state or op: both 0.
- D holds the latched CMD_D until the next load; it is 0000 after reset.
- CMD_VALID outside IDLE is ignored and never queued.
- ABORT in IDLE or DONE is ignored.
- CMD_CNT at its maximum (7 with the default width) performs 7 steps; the counter never wraps.

## Timing
- Reset (CLRb = 0, asynchronous) forces:
  - State IDLE.
  - S = 00, D = 0000, SDL = SDR = 0.
  - DONE = 0, ABORTED = 0, BUSY = 0, CMD_READY = 1.
- Reset mid-command discards the command. S = 00 immediately makes the register hold; no partial step is issued after release.
- Command accepted at edge k:
  - The register acts at edges k+1 … k+N, where N = steps (1 for load).
  - DONE is high in the cycle after edge k+N.
  - CMD_READY is high again after edge k+N+1.
  - Throughput is one command per N+2 cycles.
- CNT = 0 command accepted at edge k: DONE is high in cycle k+1; the register never leaves hold.
- SIN and Q_FB are sampled by the register at the same edge they feed through. Q_FB is the pre-edge value, so rotate is exact.

## Test plan
- Reset, then load: reset, then load CMD_D = 1010 → S = 11 for exactly one cycle; the register holds 1010; DONE pulses at k+2; CMD_READY returns at k+3.
- Shift left with serial input: after loading 0001, shift left CNT = 3 with SIN = 1,0,1 → S = 10 for 3 cycles; Q = 1101; DONE one cycle after.
- Rotate and shift right: from 1001, rotate left CNT = 5 → Q = 0011. Then shift right CNT = 2 with SIN = 0 → Q = 0000.
- Abort mid-command: after loading 1111, shift left CNT = 7 with SIN = 0, and ABORT asserted at the 2nd RUN edge → 2 steps; Q = 1100; DONE and ABORTED = 1 together.
- CNT = 0 and busy stall: a CNT = 0 command → DONE next cycle, Q unchanged. A second CMD_VALID held during RUN → not accepted until CMD_READY = 1, then executed once.
- Asynchronous reset mid-command: CLRb pulsed low mid-shift between edges → S = 00 immediately, BUSY = 0, DONE never pulses for the killed command.
